// File: rtl/gpu_pkg.sv
// Shared GPU types: dispatcher state encoding and the packed voxel record {id,z,y,x}.
// voxel_rec_t uses the default field widths (8-bit coordinates, 8-bit id).
package gpu_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    LOOKUP = 3'd2,
    RASTER = 3'd3,
    SHADE  = 3'd4,
    FINISH = 3'd5
  } disp_state_t;

  localparam int REC_COORD_BITS   = 8;
  localparam int REC_PALETTE_BITS = 8;

  typedef struct packed {
    logic [REC_PALETTE_BITS-1:0] id;
    logic [REC_COORD_BITS-1:0]   z;
    logic [REC_COORD_BITS-1:0]   y;
    logic [REC_COORD_BITS-1:0]   x;
  } voxel_rec_t;

  function automatic voxel_rec_t make_voxel(input logic [REC_PALETTE_BITS-1:0] id,
                                            input logic [REC_COORD_BITS-1:0] z,
                                            input logic [REC_COORD_BITS-1:0] y,
                                            input logic [REC_COORD_BITS-1:0] x);
    voxel_rec_t rec;
    rec.id = id;
    rec.z  = z;
    rec.y  = y;
    rec.x  = x;
    return rec;
  endfunction

endpackage

// File: rtl/voxel_dispatcher.sv
// Walks the voxel list once per frame, broadcasting each record to the shader array.
// Define DISPATCH_SKIP_EMPTY_EN to skip records whose id is 0 without running any phase.
module voxel_dispatcher
  import gpu_pkg::*;
#(
  parameter int COORD_BITS   = 8,
  parameter int FRAC_BITS    = 8,
  parameter int PALETTE_BITS = 8,
  parameter int PIXEL_BITS   = 8,
  parameter int ADDR_BITS    = 16
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic                                  start,
  input  logic [ADDR_BITS-1:0]                  voxel_count,
  input  logic signed [COORD_BITS+FRAC_BITS-1:0] cam_pos_x_in,
  input  logic signed [COORD_BITS+FRAC_BITS-1:0] cam_pos_y_in,
  input  logic signed [COORD_BITS+FRAC_BITS-1:0] cam_pos_z_in,
  input  logic signed [COORD_BITS+FRAC_BITS-1:0] cam_look_x_in,
  input  logic signed [COORD_BITS+FRAC_BITS-1:0] cam_look_y_in,
  input  logic signed [COORD_BITS+FRAC_BITS-1:0] cam_look_z_in,
  output logic                                  mem_rd,
  output logic [ADDR_BITS-1:0]                  mem_addr,
  input  logic [PALETTE_BITS+3*COORD_BITS-1:0]  mem_rdata,
  output logic [PALETTE_BITS-1:0]               palette_addr,
  input  logic [PIXEL_BITS-1:0]                 palette_data,
  output logic [COORD_BITS-1:0]                 voxel_x,
  output logic [COORD_BITS-1:0]                 voxel_y,
  output logic [COORD_BITS-1:0]                 voxel_z,
  output logic [PALETTE_BITS-1:0]               voxel_id,
  output logic [PIXEL_BITS-1:0]                 palette_entry,
  output logic signed [COORD_BITS+FRAC_BITS-1:0] cam_pos_x,
  output logic signed [COORD_BITS+FRAC_BITS-1:0] cam_pos_y,
  output logic signed [COORD_BITS+FRAC_BITS-1:0] cam_pos_z,
  output logic signed [COORD_BITS+FRAC_BITS-1:0] cam_look_x,
  output logic signed [COORD_BITS+FRAC_BITS-1:0] cam_look_y,
  output logic signed [COORD_BITS+FRAC_BITS-1:0] cam_look_z,
  output logic                                  do_rasterize,
  output logic                                  do_shade,
  input  logic                                  rasterizing_done,
  input  logic                                  shading_done,
  output logic                                  busy,
  output logic                                  frame_done
);

`ifdef DISPATCH_SKIP_EMPTY_EN
  localparam bit SKIP_EMPTY = 1'b1;
`else
  localparam bit SKIP_EMPTY = 1'b0;
`endif

  localparam int CAM_W = COORD_BITS + FRAC_BITS;

  disp_state_t            state_reg;
  logic [ADDR_BITS-1:0]   count_reg;
  logic [ADDR_BITS-1:0]   idx_reg;
  logic                   raster_first_reg;

  logic [COORD_BITS-1:0]   rd_x;
  logic [COORD_BITS-1:0]   rd_y;
  logic [COORD_BITS-1:0]   rd_z;
  logic [PALETTE_BITS-1:0] rd_id;
  logic [ADDR_BITS:0]      idx_next;
  logic                    more_next;
  logic                    start_accept;

  assign rd_x = mem_rdata[COORD_BITS-1:0];
  assign rd_y = mem_rdata[2*COORD_BITS-1:COORD_BITS];
  assign rd_z = mem_rdata[3*COORD_BITS-1:2*COORD_BITS];
  assign rd_id = mem_rdata[3*COORD_BITS +: PALETTE_BITS];

  // One extra bit so a full 2^ADDR_BITS-1 record list terminates without wrapping.
  assign idx_next  = {1'b0, idx_reg} + 1'b1;
  assign more_next = idx_next < {1'b0, count_reg};
  assign start_accept = (state_reg == IDLE) && start;

  // The palette ROM needs the address during LOOKUP so its data lands in the first RASTER cycle.
  always_comb begin
    palette_addr = voxel_id;
    if (state_reg == LOOKUP) begin
      palette_addr = rd_id;
    end
  end

  // Camera is captured once per frame; changes while busy never reach the shaders.
  logic signed [CAM_W-1:0] cam_in [6];
  assign cam_in[0] = cam_pos_x_in;
  assign cam_in[1] = cam_pos_y_in;
  assign cam_in[2] = cam_pos_z_in;
  assign cam_in[3] = cam_look_x_in;
  assign cam_in[4] = cam_look_y_in;
  assign cam_in[5] = cam_look_z_in;

  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_cam
      logic signed [CAM_W-1:0] q_reg;
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          q_reg <= '0;
        end else if (start_accept) begin
          q_reg <= cam_in[gi];
        end
      end
    end
  endgenerate

  assign cam_pos_x  = g_cam[0].q_reg;
  assign cam_pos_y  = g_cam[1].q_reg;
  assign cam_pos_z  = g_cam[2].q_reg;
  assign cam_look_x = g_cam[3].q_reg;
  assign cam_look_y = g_cam[4].q_reg;
  assign cam_look_z = g_cam[5].q_reg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg        <= IDLE;
      count_reg        <= '0;
      idx_reg          <= '0;
      raster_first_reg <= 1'b0;
      mem_rd           <= 1'b0;
      mem_addr         <= '0;
      voxel_x          <= '0;
      voxel_y          <= '0;
      voxel_z          <= '0;
      voxel_id         <= '0;
      palette_entry    <= '0;
      do_rasterize     <= 1'b0;
      do_shade         <= 1'b0;
      busy             <= 1'b0;
      frame_done       <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          frame_done <= 1'b0;
          if (start) begin
            count_reg <= voxel_count;
            idx_reg   <= '0;
            busy      <= 1'b1;
            if (voxel_count == '0) begin
              state_reg  <= FINISH;
              frame_done <= 1'b1;
            end else begin
              state_reg <= FETCH;
              mem_rd    <= 1'b1;
              mem_addr  <= '0;
            end
          end
        end

        FETCH: begin
          mem_rd    <= 1'b0;
          state_reg <= LOOKUP;
        end

        LOOKUP: begin
          voxel_x  <= rd_x;
          voxel_y  <= rd_y;
          voxel_z  <= rd_z;
          voxel_id <= rd_id;
          if (SKIP_EMPTY && (rd_id == '0)) begin
            idx_reg <= idx_next[ADDR_BITS-1:0];
            if (more_next) begin
              state_reg <= FETCH;
              mem_rd    <= 1'b1;
              mem_addr  <= idx_next[ADDR_BITS-1:0];
            end else begin
              state_reg  <= FINISH;
              frame_done <= 1'b1;
            end
          end else begin
            state_reg        <= RASTER;
            do_rasterize     <= 1'b1;
            raster_first_reg <= 1'b1;
          end
        end

        RASTER: begin
          raster_first_reg <= 1'b0;
          if (raster_first_reg) begin
            palette_entry <= palette_data;
          end
          // Command is already high on entry, so a done that is high early still sees a full cycle.
          if (rasterizing_done) begin
            do_rasterize <= 1'b0;
            do_shade     <= 1'b1;
            state_reg    <= SHADE;
          end
        end

        SHADE: begin
          if (shading_done) begin
            do_shade <= 1'b0;
            idx_reg  <= idx_next[ADDR_BITS-1:0];
            if (more_next) begin
              state_reg <= FETCH;
              mem_rd    <= 1'b1;
              mem_addr  <= idx_next[ADDR_BITS-1:0];
            end else begin
              state_reg  <= FINISH;
              frame_done <= 1'b1;
            end
          end
        end

        FINISH: begin
          frame_done <= 1'b0;
          busy       <= 1'b0;
          state_reg  <= IDLE;
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/voxel_dispatcher.md
VOXEL_DISPATCHER -- requirements
Module: voxel_dispatcher

Interface
REQ-001 The block SHALL have parameter COORD_BITS, default 8, voxel coordinate width.
REQ-002 The block SHALL have parameter FRAC_BITS, default 8, camera fixed-point fraction width.
REQ-003 The block SHALL have parameter PALETTE_BITS, default 8, voxel id / palette index width.
REQ-004 The block SHALL have parameter PIXEL_BITS, default 8, palette entry width.
REQ-005 The block SHALL have parameter ADDR_BITS, default 16, voxel memory address width.
REQ-006 clock  input  1  sole clock, all state on rising edge.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 start  input  1  begin one frame dispatch, sampled in IDLE only.
REQ-009 voxel_count  input  ADDR_BITS  number of voxel records, latched at start.
REQ-010 cam_pos_x/y/z_in, cam_look_x/y/z_in  input  signed COORD_BITS+FRAC_BITS each  camera, latched at start.
REQ-011 mem_rd / mem_addr  output  1 / ADDR_BITS  voxel memory read strobe and address.
REQ-012 mem_rdata  input  PALETTE_BITS+3*COORD_BITS  record {id,z,y,x}, valid one cycle after mem_rd.
REQ-013 palette_addr / palette_data  output PALETTE_BITS / input PIXEL_BITS  palette ROM, data valid one cycle after address.
REQ-014 voxel_x/y/z, voxel_id, palette_entry, cam_pos_*, cam_look_*  output  widths as shader  values broadcast to the pixel_shader array.
REQ-015 do_rasterize, do_shade  output  1  phase commands to shaders.
REQ-016 rasterizing_done, shading_done  input  1  AND-reduced completion from all shaders.
REQ-017 busy  output  1  high from start acceptance until frame_done; frame_done  output  1  one-cycle pulse at frame end.

Function
REQ-018 FSM states SHALL be IDLE, FETCH, LOOKUP, RASTER, SHADE, FINISH.
REQ-019 IDLE + start: latch voxel_count and camera, idx<=0, go FETCH; if voxel_count==0 go FINISH.
REQ-020 FETCH (1 cycle): mem_rd=1, mem_addr=idx; go LOOKUP.
REQ-021 LOOKUP (1 cycle): register voxel_x/y/z/id from mem_rdata, drive palette_addr=id; go RASTER.
REQ-022 RASTER: first cycle registers palette_entry from palette_data; do_rasterize=1 until rasterizing_done sampled high.
REQ-023 Cycle after rasterizing_done sampled: do_rasterize=0, do_shade=1, state SHADE.
REQ-024 SHADE: do_shade=1 until shading_done sampled high; then do_shade=0, idx<=idx+1; go FETCH if idx+1<voxel_count, else FINISH.
REQ-025 do_rasterize and do_shade SHALL never be high in the same cycle.
REQ-026 voxel_*, palette_entry, cam_* outputs SHALL stay constant throughout RASTER and SHADE of a voxel.
REQ-027 FINISH (1 cycle): frame_done=1, busy=0 next cycle, go IDLE.
REQ-028 start while busy SHALL be ignored; inputs voxel_count/cam_*_in changes while busy SHALL not affect the frame.
REQ-029 idx SHALL be ADDR_BITS wide; voxel_count of 2^ADDR_BITS-1 SHALL dispatch all records without wrap.
REQ-030 done inputs already high on entry to RASTER/SHADE SHALL still hold the command for at least one cycle.

Reset
REQ-031 reset low SHALL force IDLE immediately, including mid-frame, with no frame_done.
REQ-032 Reset values: all outputs 0 (busy, frame_done, mem_rd, do_rasterize, do_shade, addresses, voxel/camera registers).

Configuration
REQ-033 With DISPATCH_SKIP_EMPTY_EN defined, a record with id==0 SHALL go LOOKUP -> advance idx (FETCH or FINISH) with no do_rasterize/do_shade.
REQ-034 Without DISPATCH_SKIP_EMPTY_EN, id==0 records SHALL be dispatched like any other.

Structure
REQ-035 gpu package SHALL hold the dispatcher state enum and the voxel record struct {id,z,y,x}.
REQ-036 No sub-module; the block is a single FSM with datapath registers.

Verification
REQ-037 voxel_count=1, record {1,0,0,0}, palette[1]=8'hff, cam_pos=2.0 each, done responses after 3 cycles -> one RASTER then SHADE, outputs x=y=z=0, palette_entry=ff, frame_done one pulse.
REQ-038 voxel_count=3 -> mem_addr 0,1,2 in order, exactly 3 do_rasterize and 3 do_shade phases, never overlapping.
REQ-039 voxel_count=0 start -> frame_done two cycles after start, no mem_rd.
REQ-040 reset low during second voxel's SHADE -> all outputs 0 asynchronously, no frame_done, next start restarts at addr 0.
REQ-041 With DISPATCH_SKIP_EMPTY_EN, records ids {1,0,2} -> two raster/shade phases, for ids 1 and 2 only; without the macro, three.
REQ-042 start pulsed again mid-frame with changed cam_pos_x_in -> ignored, cam_pos_x unchanged until next frame.
